// File: rtl/aver_matrix_gen.sv
// 3x3 sliding-window generator for an 8-bit pixel stream. Two line buffers supply
// the previous two lines; rows that do not yet have valid data in this frame read as zero.
module aver_matrix_gen #(
    parameter int unsigned IMG_H = 1280,
    parameter int unsigned AW    = 11
) (
    input  logic       video_clk,
    input  logic       rst_n,
    input  logic       per_frame_vs,
    input  logic       per_frame_de,
    input  logic [7:0] per_img_y,
    output logic       matrix_vs,
    output logic       matrix_de,
    output logic [7:0] matrix11,
    output logic [7:0] matrix12,
    output logic [7:0] matrix13,
    output logic [7:0] matrix21,
    output logic [7:0] matrix22,
    output logic [7:0] matrix23,
    output logic [7:0] matrix31,
    output logic [7:0] matrix32,
    output logic [7:0] matrix33
);

    localparam logic [AW-1:0] ColLast = AW'(IMG_H - 1);

    logic [7:0]      lb1_q [IMG_H];
    logic [7:0]      lb2_q [IMG_H];

    logic [AW-1:0]   col_q, col_d;
    logic [1:0]      vs_q, de_q;
    logic [7:0]      y1_q, lb1_rd_q, lb2_rd_q;
    logic [1:0]      row_cnt_q, row_cnt_d;
    // Index 2 is the oldest pixel (column 1), index 0 the newest (column 3).
    logic [2:0][7:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;

    always_comb begin
        col_d = '0;
        if (per_frame_de) begin
            col_d = (col_q == ColLast) ? '0 : col_q + 1'b1;
        end
    end

    always_comb begin
        row_cnt_d = row_cnt_q;
        if (per_frame_vs && !vs_q[0]) begin
            row_cnt_d = 2'd0;
        end else if (!per_frame_de && de_q[0] && row_cnt_q != 2'd2) begin
            row_cnt_d = row_cnt_q + 2'd1;
        end
    end

    // Rows without a full line of history in this frame are forced to zero.
    always_comb begin
        r1_d = '0;
        r2_d = '0;
        r3_d = '0;
        if (de_q[0]) begin
            r3_d = {r3_q[1:0], y1_q};
            if (row_cnt_q != 2'd0) begin
                r2_d = {r2_q[1:0], lb1_rd_q};
            end
            if (row_cnt_q == 2'd2) begin
                r1_d = {r1_q[1:0], lb2_rd_q};
            end
        end
    end

    // Line buffers are deliberately not reset; stale contents are hidden by row gating.
    always_ff @(posedge video_clk) begin
        if (per_frame_de) begin
            lb1_q[col_q] <= per_img_y;
            lb2_q[col_q] <= lb1_q[col_q];
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            vs_q      <= '0;
            de_q      <= '0;
            y1_q      <= '0;
            lb1_rd_q  <= '0;
            lb2_rd_q  <= '0;
            row_cnt_q <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            r3_q      <= '0;
        end else begin
            col_q     <= col_d;
            vs_q      <= {vs_q[0], per_frame_vs};
            de_q      <= {de_q[0], per_frame_de};
            y1_q      <= per_img_y;
            lb1_rd_q  <= lb1_q[col_q];
            lb2_rd_q  <= lb2_q[col_q];
            row_cnt_q <= row_cnt_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            r3_q      <= r3_d;
        end
    end

    assign matrix_vs = vs_q[1];
    assign matrix_de = de_q[1];
    assign matrix11  = r1_q[2];
    assign matrix12  = r1_q[1];
    assign matrix13  = r1_q[0];
    assign matrix21  = r2_q[2];
    assign matrix22  = r2_q[1];
    assign matrix23  = r2_q[0];
    assign matrix31  = r3_q[2];
    assign matrix32  = r3_q[1];
    assign matrix33  = r3_q[0];

endmodule

// File: doc/aver_matrix_gen.md
AVER_MATRIX_GEN -- requirements
Module: aver_matrix_gen

Interface
REQ-001 The block SHALL have parameter IMG_H, default 1280, meaning active pixels per line (line-buffer depth, legal range 4..2048).
REQ-002 The block SHALL have parameter AW, default 11, meaning the line-buffer address width (2^AW >= IMG_H).
REQ-003 video_clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 per_frame_vs  input  1  frame sync of the incoming video stream.
REQ-006 per_frame_de  input  1  data-enable; high for each valid pixel of a line.
REQ-007 per_img_y  input  8  incoming pixel (luma).
REQ-008 matrix_vs  output  1  per_frame_vs delayed 2 clk.
REQ-009 matrix_de  output  1  per_frame_de delayed 2 clk; qualifies the window.
REQ-010 matrix11..matrix33  output  8 each  3x3 window; row 1 = two lines ago, row 3 = current line; column 1 = oldest pixel, column 3 = newest pixel.

Function
REQ-011 The block SHALL keep a column address col (AW bits), incremented on each cycle with per_frame_de=1 and cleared to 0 on each cycle with per_frame_de=0.
REQ-012 col SHALL wrap from IMG_H-1 to 0 if a line exceeds IMG_H pixels; no error flag.
REQ-013 The block SHALL hold two line buffers LB1 and LB2, each IMG_H x 8 bit, single clock, read-before-write at the same address.
REQ-014 On a cycle with per_frame_de=1 at address col: read LB1[col] and LB2[col]; write LB1[col] <= per_img_y and LB2[col] <= old LB1[col].
REQ-015 Read data SHALL be registered (stage 1, +1 clk); per_img_y SHALL be registered in parallel to stay aligned.
REQ-016 Stage 2 (+1 clk) SHALL shift each row: x1 <= x2, x2 <= x3, x3 <= stage-1 data; row 3 uses the delayed pixel, row 2 uses LB1 data, row 1 uses LB2 data.
REQ-017 When the stage-1 de copy is 0, all nine window registers SHALL load 0. The first pixel of a line therefore has columns 1-2 equal to 0, and the second pixel has column 1 equal to 0.
REQ-018 A row counter (2 bits, saturating at 2) SHALL increment on each falling edge of per_frame_de and clear on the rising edge of per_frame_vs.
REQ-019 Row gating SHALL apply: row_cnt=0 forces rows 1 and 2 to 0; row_cnt=1 forces row 1 to 0; row_cnt=2 passes all rows.
REQ-020 Total latency SHALL be 2 clk from a per_frame_de=1 pixel to matrix_de=1 with that pixel in matrix33.
REQ-021 matrix_vs and matrix_de SHALL be 2-stage shift registers of per_frame_vs and per_frame_de, exactly aligned with the window data.
REQ-022 If vs rises while de=1, the row counter SHALL clear and the current line continues to be written. Rows 1-2 are zero-gated from the next pixel on.
REQ-023 Line-buffer contents SHALL NOT be cleared by vs or reset; stale data is hidden only by the row gating.

Reset
REQ-024 While rst_n=0, all outputs, stage registers, col and row_cnt SHALL be 0.
REQ-025 Deassertion SHALL take effect on the next video_clk edge. Reset asserted mid-line aborts the line; the block resumes at the next vs/de.

Verification
REQ-026 IMG_H=4, vs pulse then line 0 = 10,20,30,40 -> matrix_de high 2 clk after de. Consecutive matrix31/32/33 = (0,0,10), (0,10,20), (10,20,30), (20,30,40). Rows 1-2 are all 0.
REQ-027 Line 1 = 50,60,70,80 after line 0 -> on the 4th output, row 2 = 20,30,40 and row 3 = 60,70,80. Row 1 stays 0.
REQ-028 Line 2 = 90,100,110,120 -> on the 3rd output, matrix11..33 = 10,20,30 / 50,60,70 / 90,100,110.
REQ-029 A new vs after 3 lines, then line 170,... -> rows 1-2 return to 0 despite stale buffer data, and row_cnt restarts.
REQ-030 rst_n pulsed low for 1 clk mid-line -> all outputs 0 immediately (asynchronous). The next line is processed with col starting at 0.
REQ-031 IMG_H=4 with a 5-pixel line -> the 5th pixel is written at address 0 and no X appears on the outputs.
